// File: rtl/remote_result_receiver_if.sv
`default_nettype none
// =============================================================================
// Module   : remote_result_receiver_if
// Brief    : Serial input and display-side result bundle of the result receiver.
// Revision : 1.0 - initial release
// =============================================================================
interface remote_result_receiver_if;
    logic       rxd;
    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic       sign;
    logic       overflow;
    logic       resultValid;
    logic       frameError;
    logic       checksumError;

    // master: line driver / display consumer; slave: the receiver block
    modport master (
        output rxd,
        input  num1, num2, num3, num4, sign, overflow,
        input  resultValid, frameError, checksumError
    );

    modport slave (
        input  rxd,
        output num1, num2, num3, num4, sign, overflow,
        output resultValid, frameError, checksumError
    );
endinterface
`default_nettype wire

// File: rtl/remote_result_receiver.sv
`default_nettype none
// =============================================================================
// Module   : remote_result_receiver
// Brief    : 8N1 UART receiver + result-frame parser with signed-to-BCD output.
//            Define RX_CHECKSUM_EN for the 4-byte frame with checksum check.
// Revision : 1.0 - initial release
// =============================================================================
module remote_result_receiver #(
    parameter int clkFreq     = 50000000,
    parameter int baudRate    = 9600,
    parameter int timeoutBits = 20
) (
    input  wire logic               clk,
    input  wire logic               reset,
    remote_result_receiver_if.slave bus
);
    localparam int         c_DIV    = clkFreq / (baudRate * 16);
    localparam int         c_DIV_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int         c_TO     = timeoutBits * 16;
    localparam int         c_TO_W   = $clog2(c_TO + 1);
    localparam logic [7:0] c_HEADER = 8'h3D;

    typedef enum logic [2:0] {
        R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_STOP = 3'd3, R_BREAK = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0, P_HI = 3'd1, P_LO = 3'd2, P_SUM = 3'd3, P_CONV = 3'd4, P_LOAD = 3'd5
    } p_state_t;

    logic               r_rx_meta, r_rx_sync, r_rx_prev;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               w_tick, w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
            r_div_cnt <= '0;
        end else begin
            r_rx_meta <= bus.rxd;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_div_cnt <= w_tick ? '0 : r_div_cnt + c_DIV_W'(1);
        end
    end

    assign w_tick = (r_div_cnt == c_DIV_W'(c_DIV - 1));
    assign w_fall = r_rx_prev & ~r_rx_sync;

    // ---------------- byte receiver ----------------
    rx_state_t  r_rx_state, w_rx_next;
    logic [3:0] r_tick_cnt, w_tick_cnt_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_byte_valid, w_byte_valid_next;
    logic       r_frame_err, w_frame_err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state   <= R_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_tick_cnt   <= w_tick_cnt_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_byte_valid <= w_byte_valid_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    always_comb begin
        w_rx_next         = r_rx_state;
        w_tick_cnt_next   = r_tick_cnt;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_byte_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;
        case (r_rx_state)
            R_IDLE: if (w_fall) begin
                w_rx_next       = R_START;
                w_tick_cnt_next = '0;
            end
            R_START: if (w_tick) begin
                if (r_tick_cnt == 4'd7) begin
                    w_tick_cnt_next = '0;
                    w_bit_cnt_next  = '0;
                    w_rx_next       = r_rx_sync ? R_IDLE : R_DATA;
                end else begin
                    w_tick_cnt_next = r_tick_cnt + 4'd1;
                end
            end
            R_DATA: if (w_tick) begin
                w_tick_cnt_next = r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd15) begin
                    w_shift_next   = {r_rx_sync, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7)
                        w_rx_next = R_STOP;
                end
            end
            R_STOP: if (w_tick) begin
                w_tick_cnt_next = r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd15) begin
                    if (r_rx_sync) begin
                        w_byte_valid_next = 1'b1;
                        w_rx_next         = R_IDLE;
                    end else begin
                        w_frame_err_next  = 1'b1;
                        w_rx_next         = R_BREAK;
                    end
                end
            end
            R_BREAK: if (r_rx_sync) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    // ---------------- frame parser ----------------
    p_state_t          r_p_state, w_p_next;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              w_timeout;
    logic [7:0]        r_hi;
`ifdef RX_CHECKSUM_EN
    logic [7:0]        r_lo;
`endif
    logic [15:0]       w_value, w_mag;
    logic [15:0]       r_bin;
    logic [19:0]       r_bcd;
    logic [15:0]       w_bcd_adj;
    logic [19:0]       w_bcd_shift;
    logic [3:0]        r_conv_cnt;
    logic              r_neg;
    logic [3:0]        r_num1, r_num2, r_num3, r_num4;
    logic              r_sign, r_overflow, r_result_valid, r_cksum_err;

    assign w_timeout = (r_to_cnt == c_TO_W'(c_TO));

`ifdef RX_CHECKSUM_EN
    assign w_value = {r_hi, r_lo};
`else
    assign w_value = {r_hi, r_shift};
`endif
    // Unsigned 16-bit negate, so 0x8000 maps to 32768.
    assign w_mag = w_value[15] ? (~w_value + 16'd1) : w_value;

    // The top digit never reaches 5 before the final shift, so it needs no adjust.
    always_comb begin
        w_bcd_adj = r_bcd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end
    assign w_bcd_shift = {r_bcd[18:16], w_bcd_adj, r_bin[15]};

    always_ff @(posedge clk) begin
        if (reset) r_p_state <= P_IDLE;
        else       r_p_state <= w_p_next;
    end

    always_comb begin
        w_p_next = r_p_state;
        case (r_p_state)
            P_IDLE: if (r_byte_valid && r_shift == c_HEADER) w_p_next = P_HI;
            P_HI: begin
                if (r_byte_valid)   w_p_next = P_LO;
                else if (w_timeout) w_p_next = P_IDLE;
            end
            P_LO: begin
`ifdef RX_CHECKSUM_EN
                if (r_byte_valid)   w_p_next = P_SUM;
`else
                if (r_byte_valid)   w_p_next = P_CONV;
`endif
                else if (w_timeout) w_p_next = P_IDLE;
            end
`ifdef RX_CHECKSUM_EN
            P_SUM: begin
                if (r_byte_valid)   w_p_next = (r_shift == (r_hi ^ r_lo)) ? P_CONV : P_IDLE;
                else if (w_timeout) w_p_next = P_IDLE;
            end
`endif
            P_CONV: if (r_conv_cnt == 4'd15) w_p_next = P_LOAD;
            P_LOAD: w_p_next = P_IDLE;
            default: w_p_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt       <= '0;
            r_hi           <= '0;
`ifdef RX_CHECKSUM_EN
            r_lo           <= '0;
`endif
            r_bin          <= '0;
            r_bcd          <= '0;
            r_conv_cnt     <= '0;
            r_neg          <= 1'b0;
            r_num1         <= '0;
            r_num2         <= '0;
            r_num3         <= '0;
            r_num4         <= '0;
            r_sign         <= 1'b0;
            r_overflow     <= 1'b0;
            r_result_valid <= 1'b0;
            r_cksum_err    <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_cksum_err    <= 1'b0;
            if (r_byte_valid)
                r_to_cnt <= '0;
            else if (w_tick && !w_timeout)
                r_to_cnt <= r_to_cnt + c_TO_W'(1);

            case (r_p_state)
                P_HI: if (r_byte_valid) r_hi <= r_shift;
                P_LO: if (r_byte_valid) begin
`ifdef RX_CHECKSUM_EN
                    r_lo <= r_shift;
`else
                    r_bin      <= w_mag;
                    r_bcd      <= '0;
                    r_conv_cnt <= '0;
                    r_neg      <= w_value[15];
`endif
                end
`ifdef RX_CHECKSUM_EN
                P_SUM: if (r_byte_valid) begin
                    if (r_shift == (r_hi ^ r_lo)) begin
                        r_bin      <= w_mag;
                        r_bcd      <= '0;
                        r_conv_cnt <= '0;
                        r_neg      <= w_value[15];
                    end else begin
                        r_cksum_err <= 1'b1;
                    end
                end
`endif
                P_CONV: begin
                    r_bin      <= {r_bin[14:0], 1'b0};
                    r_bcd      <= w_bcd_shift;
                    r_conv_cnt <= r_conv_cnt + 4'd1;
                end
                P_LOAD: begin
                    if (r_bcd[19:16] != 4'd0) begin
                        {r_num1, r_num2, r_num3, r_num4} <= 16'h9999;
                        r_overflow <= 1'b1;
                    end else begin
                        {r_num1, r_num2, r_num3, r_num4} <= r_bcd[15:0];
                        r_overflow <= 1'b0;
                    end
                    // A negative value is never zero, so the sign bit alone suffices.
                    r_sign         <= r_neg;
                    r_result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.num1          = r_num1;
    assign bus.num2          = r_num2;
    assign bus.num3          = r_num3;
    assign bus.num4          = r_num4;
    assign bus.sign          = r_sign;
    assign bus.overflow      = r_overflow;
    assign bus.resultValid   = r_result_valid;
    assign bus.frameError    = r_frame_err;
    assign bus.checksumError = r_cksum_err;
endmodule
`default_nettype wire

// File: tb/tb_remote_result_receiver.sv
`default_nettype none
// =============================================================================
// Module   : tb_remote_result_receiver
// Brief    : Directed self-checking bench for remote_result_receiver (div=10).
// Revision : 1.0 - initial release
// =============================================================================
module tb_remote_result_receiver;
    localparam int c_BIT = 160;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    remote_result_receiver_if bus();

    remote_result_receiver #(
        .clkFreq    (1600000),
        .baudRate   (10000),
        .timeoutBits(20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, bv_cyc = 0, rv_cyc = 0;
    int bv_cnt = 0, rv_cnt = 0, fe_cnt = 0, ce_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (dut.r_byte_valid === 1'b1) begin bv_cnt++; bv_cyc = cyc; end
        if (bus.resultValid === 1'b1)    begin rv_cnt++; rv_cyc = cyc; end
        if (bus.frameError === 1'b1)     fe_cnt++;
        if (bus.checksumError === 1'b1)  ce_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bus.rxd = 1'b0;
        idle(c_BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rxd = b[i];
            idle(c_BIT);
        end
        bus.rxd = stop;
        idle(c_BIT);
        bus.rxd = 1'b1;
        idle(20);
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input logic [7:0] sum);
        send_byte(8'h3D, 1'b1);
        send_byte(hi, 1'b1);
        send_byte(lo, 1'b1);
`ifdef RX_CHECKSUM_EN
        send_byte(sum, 1'b1);
`else
        if (sum === 8'hxx) idle(1);
`endif
        idle(20);
    endtask

    task automatic check_outputs(input string tag, input logic [15:0] dig, input logic sgn, input logic ovf);
        check({tag, "_digits"}, {16'd0, bus.num1, bus.num2, bus.num3, bus.num4}, {16'd0, dig});
        check({tag, "_sign"}, {31'd0, bus.sign}, {31'd0, sgn});
        check({tag, "_ovf"}, {31'd0, bus.overflow}, {31'd0, ovf});
    endtask

    task automatic run_frame(input string tag, input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] sum, input logic [15:0] dig,
                             input logic sgn, input logic ovf);
        int rv0;
        rv0 = rv_cnt;
        send_frame(hi, lo, sum);
        check_outputs(tag, dig, sgn, ovf);
        check({tag, "_rv_count"}, rv_cnt - rv0, 1);
        check({tag, "_latency"}, rv_cyc - bv_cyc, 18);
    endtask

    initial begin
        int rv0, fe0, bv0, ce0;
        bus.rxd = 1'b1;
        reset   = 1'b1;
        idle(5);
        reset   = 1'b0;
        idle(2);
        check_outputs("reset", 16'h0000, 1'b0, 1'b0);
        check("reset_pulses", {29'd0, bus.resultValid, bus.frameError, bus.checksumError}, 0);

        run_frame("f1234", 8'h04, 8'hD2, 8'hD6, 16'h1234, 1'b0, 1'b0);
        run_frame("fm123", 8'hFF, 8'h85, 8'h7A, 16'h0123, 1'b1, 1'b0);

`ifdef RX_CHECKSUM_EN
        rv0 = rv_cnt;
        ce0 = ce_cnt;
        send_frame(8'h04, 8'hD2, 8'h00);
        check("cksum_err_count", ce_cnt - ce0, 1);
        check("cksum_no_rv", rv_cnt - rv0, 0);
        check_outputs("cksum_hold", 16'h0123, 1'b1, 1'b0);
`endif

        run_frame("fm32768", 8'h80, 8'h00, 8'h80, 16'h9999, 1'b1, 1'b1);

        // Reset in the middle of the second byte of a frame
        send_byte(8'h3D, 1'b1);
        bus.rxd = 1'b0;
        idle(400);
        reset = 1'b1;
        idle(3);
        bus.rxd = 1'b1;
        reset   = 1'b0;
        idle(2);
        check_outputs("midreset", 16'h0000, 1'b0, 1'b0);
        idle(c_BIT * 2);

        run_frame("f10000", 8'h27, 8'h10, 8'h37, 16'h9999, 1'b0, 1'b1);
        run_frame("fzero", 8'h00, 8'h00, 8'h00, 16'h0000, 1'b0, 1'b0);

        // Stop bit held low
        rv0 = rv_cnt;
        fe0 = fe_cnt;
        bv0 = bv_cnt;
        send_byte(8'h55, 1'b0);
        idle(40);
        check("frame_err_count", fe_cnt - fe0, 1);
        check("frame_err_no_byte", bv_cnt - bv0, 0);
        check("frame_err_no_rv", rv_cnt - rv0, 0);

        // 3-cycle low glitch
        bv0 = bv_cnt;
        fe0 = fe_cnt;
        bus.rxd = 1'b0;
        idle(3);
        bus.rxd = 1'b1;
        idle(c_BIT * 12);
        check("glitch_no_byte", bv_cnt - bv0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);

        // Inter-byte gap longer than the timeout
        rv0 = rv_cnt;
        send_byte(8'h3D, 1'b1);
        send_byte(8'h04, 1'b1);
        idle(c_BIT * 25);
        send_byte(8'hD2, 1'b1);
`ifdef RX_CHECKSUM_EN
        send_byte(8'hD6, 1'b1);
`endif
        idle(40);
        check("timeout_no_rv", rv_cnt - rv0, 0);
        check_outputs("timeout_hold", 16'h0000, 1'b0, 1'b0);

`ifndef RX_CHECKSUM_EN
        check("no_cksum_err", ce_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
